// File: rtl/huff_translation.sv
// Huffman encoder back-end: latches one codeword per character and shifts its
// code bits out MSB-first, one per clock, until totChar characters (or EOF) are done.
module huff_translation (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  totChar,
    input  logic [7:0]   charIn,
    input  logic [127:0] path,
    output logic         writeBin,
    output logic         bitValid,
    output logic         charDone,
    output logic         done
);

    localparam logic [6:0] MAX_LEN = 7'd121;
    localparam logic [7:0] EOF_CH  = 8'h1A;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state_q;
    logic [31:0]    tot_q;
    logic [31:0]    cnt_q;
    logic [7:0]     char_q;
    logic [120:0]   code_q;
    logic [6:0]     idx_q;
    logic           writeBin_q;
    logic           bitValid_q;
    logic           charDone_q;
    logic           done_q;

    logic [6:0]     len_in;
    logic [6:0]     len_m1;
    logic [120:0]   code_in;
    logic           len_ok;
    logic [31:0]    cnt_d;
    logic [6:0]     idx_d;
    logic           last_char;

    always_comb begin
        len_in    = path[6:0];
        len_m1    = len_in - 7'd1;
        code_in   = path[127:7];
        len_ok    = (len_in != 7'd0) && (len_in <= MAX_LEN);
        cnt_d     = cnt_q + 32'd1;
        idx_d     = idx_q - 7'd1;
        last_char = (cnt_d == tot_q) || (char_q == EOF_CH);
    end

    // Outputs are registered on the transition into the state they belong to,
    // so the first code bit is visible in the cycle right after LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tot_q      <= '0;
            cnt_q      <= '0;
            char_q     <= '0;
            code_q     <= '0;
            idx_q      <= '0;
            writeBin_q <= 1'b0;
            bitValid_q <= 1'b0;
            charDone_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            writeBin_q <= 1'b0;
            bitValid_q <= 1'b0;
            charDone_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tot_q <= totChar;
                    if (totChar == 32'd0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    char_q <= charIn;
                    code_q <= code_in;
                    if (len_ok) begin
                        idx_q      <= len_m1;
                        writeBin_q <= code_in[len_m1];
                        bitValid_q <= 1'b1;
                        state_q    <= S_SHIFT;
                    end else begin
                        // Zero or oversized length: skip the character, emit no bits.
                        charDone_q <= 1'b1;
                        state_q    <= S_NEXT;
                    end
                end
                S_SHIFT: begin
                    if (idx_q == 7'd0) begin
                        charDone_q <= 1'b1;
                        state_q    <= S_NEXT;
                    end else begin
                        idx_q      <= idx_d;
                        writeBin_q <= code_q[idx_d];
                        bitValid_q <= 1'b1;
                    end
                end
                S_NEXT: begin
                    cnt_q <= cnt_d;
                    if (last_char) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign writeBin = writeBin_q;
    assign bitValid = bitValid_q;
    assign charDone = charDone_q;
    assign done     = done_q;

endmodule

// File: tb/tb_huff_translation.sv
// Scoreboard bench for huff_translation: expected code bits are queued per
// character as stimulus is prepared and popped as bitValid cycles appear.
module tb_huff_translation;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  totChar;
    logic [7:0]   charIn;
    logic [127:0] path;
    logic         writeBin;
    logic         bitValid;
    logic         charDone;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] stim_path[$];
    logic [7:0]   stim_char[$];
    bit           exp_bits[$];
    int           exp_len[$];

    always #5 clk = ~clk;

    huff_translation dut (
        .clk      (clk),
        .rst      (rst),
        .totChar  (totChar),
        .charIn   (charIn),
        .path     (path),
        .writeBin (writeBin),
        .bitValid (bitValid),
        .charDone (charDone),
        .done     (done)
    );

    task automatic clear_sb();
        stim_path.delete();
        stim_char.delete();
        exp_bits.delete();
        exp_len.delete();
    endtask

    // Expected bits: code bits path[7+L-1] down to path[7]; L outside 1..121 yields none.
    task automatic push_char(input logic [127:0] p, input logic [7:0] c);
        int len;
        len = int'(p[6:0]);
        stim_path.push_back(p);
        stim_char.push_back(c);
        if (len >= 1 && len <= 121) begin
            for (int i = len - 1; i >= 0; i--) exp_bits.push_back(p[7 + i]);
            exp_len.push_back(len);
        end else begin
            exp_len.push_back(0);
        end
    endtask

    function automatic logic [127:0] rand_path(input int len);
        logic [127:0] p;
        p = {$urandom, $urandom, $urandom, $urandom};
        p[6:0] = len[6:0];
        return p;
    endfunction

    task automatic do_reset(input logic [31:0] tot);
        rst     = 1'b1;
        totChar = tot;
        path    = '0;
        charIn  = '0;
        clear_sb();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs nchars characters from the stimulus queues, checking every sampled cycle.
    task automatic translate(input int nchars, input int budget, input string tag,
                             output int first_bit, output int first_done);
        int  seen;
        int  bits;
        int  cyc;
        int  el;
        bit  e;
        seen = 0; bits = 0; cyc = 0; first_bit = -1; first_done = -1;
        if (stim_path.size() > 0) begin
            path   = stim_path.pop_front();
            charIn = stim_char.pop_front();
        end
        while (seen < nchars && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bitValid) begin
                if (first_bit < 0) first_bit = cyc;
                n_tests++;
                if (exp_bits.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_bit: got bitValid=1 writeBin=%0b, expected no bit", tag, writeBin);
                end else begin
                    e = exp_bits.pop_front();
                    if (writeBin !== e) begin
                        n_fail++;
                        $display("FAIL %s bit: got writeBin=%0b, expected %0b (char %0d bit %0d)", tag, writeBin, e, seen, bits);
                    end
                end
                bits++;
            end else begin
                n_tests++;
                if (writeBin !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s idle_bit: got writeBin=%0b with bitValid=0, expected 0", tag, writeBin);
                end
            end
            if (charDone) begin
                if (first_done < 0) first_done = cyc;
                el = (exp_len.size() > 0) ? exp_len.pop_front() : -1;
                n_tests++;
                if (bits !== el) begin
                    n_fail++;
                    $display("FAIL %s bit_count: got %0d bits, expected %0d (char %0d)", tag, bits, el, seen);
                end
                bits = 0;
                seen++;
                if (stim_path.size() > 0) begin
                    path   = stim_path.pop_front();
                    charIn = stim_char.pop_front();
                end
            end
        end
        n_tests++;
        if (seen != nchars) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d charDone pulses, expected %0d", tag, seen, nchars);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; totChar = 32'd1; charIn = 8'h41; path = {128{1'b1}};
        clear_sb();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({writeBin, bitValid, charDone, done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b, expected 0000 (cycle %0d)", {writeBin, bitValid, charDone, done}, i);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_code();
        int fb, fd;
        do_reset(32'd5);
        push_char(128'h4000A, 8'h41);
        translate(1, 40, "zero_code", fb, fd);
        n_tests++;
        if (fb !== 2) begin
            n_fail++;
            $display("FAIL zero_code latency: got first bit at cycle %0d, expected 2", fb);
        end
        n_tests++;
        if (fd !== 12) begin
            n_fail++;
            $display("FAIL zero_code char_time: got charDone at cycle %0d, expected 12", fd);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_code not_done: got done=%0b, expected 0", done);
        end
    endtask

    task automatic test_skip();
        int fb, fd;
        do_reset(32'd3);
        push_char({128{1'b1}}, 8'h42);
        push_char(128'h0, 8'h43);
        push_char(128'h8608B, 8'h44);
        translate(3, 60, "skip", fb, fd);
        n_tests++;
        if (fd !== 2) begin
            n_fail++;
            $display("FAIL skip char_time: got charDone at cycle %0d, expected 2", fd);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL skip done: got done=%0b, expected 1", done);
        end
    endtask

    task automatic test_count_done();
        int fb, fd;
        do_reset(32'd3);
        push_char(128'h4000A, 8'h41);
        push_char(128'h8608B, 8'h42);
        push_char(128'h2A305, 8'h43);
        translate(3, 80, "count", fb, fd);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL count done: got done=%0b, expected 1", done);
        end
        path = rand_path(20);
        charIn = 8'h55;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if ({writeBin, bitValid, charDone, done} !== 4'b0001) begin
                n_fail++;
                $display("FAIL count hold: got %b, expected 0001", {writeBin, bitValid, charDone, done});
            end
        end
    endtask

    task automatic test_tot_zero();
        do_reset(32'd0);
        path = 128'h4000A;
        @(negedge clk);
        n_tests++;
        if ({writeBin, bitValid, charDone, done} !== 4'b0001) begin
            n_fail++;
            $display("FAIL tot_zero: got %b, expected 0001", {writeBin, bitValid, charDone, done});
        end
    endtask

    task automatic test_eof();
        int fb, fd;
        do_reset(32'd10);
        push_char(128'h8608B, 8'h1A);
        translate(1, 40, "eof", fb, fd);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL eof done: got done=%0b, expected 1", done);
        end
    endtask

    task automatic test_mid_reset();
        int fb, fd;
        do_reset(32'd2);
        push_char(128'h4000A, 8'h41);
        push_char(rand_path(30), 8'h42);
        translate(1, 40, "mid_a", fb, fd);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({writeBin, bitValid, charDone, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset outputs: got %b, expected 0000", {writeBin, bitValid, charDone, done});
        end
        do_reset(32'd2);
        push_char(rand_path(7), 8'h43);
        translate(1, 40, "mid_b", fb, fd);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset count: got done=%0b after first char, expected 0", done);
        end
        push_char(rand_path(13), 8'h44);
        translate(1, 40, "mid_c", fb, fd);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset done: got done=%0b, expected 1", done);
        end
    endtask

    task automatic test_back_to_back();
        int fb, fd;
        int lens[6] = '{1, 121, 64, 2, 122, 37};
        do_reset(32'd6);
        for (int i = 0; i < 6; i++) push_char(rand_path(lens[i]), 8'h30 + 8'(i));
        translate(6, 400, "b2b", fb, fd);
        n_tests++;
        if (exp_bits.size() != 0) begin
            n_fail++;
            $display("FAIL b2b leftover: got %0d unconsumed expected bits, expected 0", exp_bits.size());
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b done: got done=%0b, expected 1", done);
        end
    endtask

    initial begin
        rst = 1'b1; totChar = '0; charIn = '0; path = '0;
        test_reset();
        test_zero_code();
        test_skip();
        test_count_done();
        test_tot_zero();
        test_eof();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
